// File: rtl/gen1_descramble_pkg.sv
// Shared definitions for the Gen1/Gen2 receive descrambler.
//  - 8b/10b K symbol codes used for ordered-set tracking (COM, SKP, PAD_)
//  - descrambler state encoding (enum for readability, localparams for the RTL)
//  - track_t: the LFSR/ordered-set tracking state threaded symbol-to-symbol
//  - lfsr_adv8: advance the x^16+x^5+x^4+x^3+1 LFSR by one symbol (8 shifts)
package gen1_descramble_pkg;

  localparam logic [7:0]  COM  = 8'hBC;
  localparam logic [7:0]  SKP  = 8'h1C;
  localparam logic [7:0]  PAD_ = 8'hF7;

  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hFFFF;
  localparam int          OS_LEN_DEFAULT    = 16;
  // Galois feedback taps for x^5+x^4+x^3+1 (x^16 is the shifted-out bit).
  localparam logic [15:0] LFSR_TAPS         = 16'h0039;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    OS_ID     = 2'd1,
    SCRAMBLED = 2'd2,
    TS_BYPASS = 2'd3
  } descr_state_e;

  localparam logic [1:0] ST_UNLOCKED  = UNLOCKED;
  localparam logic [1:0] ST_OS_ID     = OS_ID;
  localparam logic [1:0] ST_SCRAMBLED = SCRAMBLED;
  localparam logic [1:0] ST_TS_BYPASS = TS_BYPASS;

  typedef struct packed {
    logic [15:0] lfsr;
    logic [1:0]  st;
    logic [3:0]  os_cnt;
    logic        lock;
  } track_t;

  function automatic logic [15:0] lfsr_adv8(input logic [15:0] l);
    logic [15:0] s;
    s = l;
    for (int i = 0; i < 8; i++) begin
      s = s[15] ? ({s[14:0], 1'b0} ^ LFSR_TAPS) : {s[14:0], 1'b0};
    end
    return s;
  endfunction

endpackage

// File: rtl/gen1_descramble_if.sv
// PIPE RX symbol bus into the descrambler and descrambled bus out of it.
// Handshake: valid-only. A beat is transferred on every clk_i edge where
// data_valid_i is high; there is no ready/backpressure. data_valid_o marks
// output beats the same way, two cycles after the matching input beat.
//  master: drives data_in_i/data_k_in_i/data_valid_i/pipe_width_i
//  slave : the descrambler; drives data_out_o/data_k_out_o/data_valid_o,
//          lock_o and the state_o debug view of the tracking FSM.
interface gen1_descramble_if;
  logic [31:0] data_in_i;
  logic [3:0]  data_k_in_i;
  logic        data_valid_i;
  logic [5:0]  pipe_width_i;
  logic [31:0] data_out_o;
  logic [3:0]  data_k_out_o;
  logic        data_valid_o;
  logic        lock_o;
  logic [1:0]  state_o;

  modport master (
    output data_in_i, data_k_in_i, data_valid_i, pipe_width_i,
    input  data_out_o, data_k_out_o, data_valid_o, lock_o, state_o
  );

  modport slave (
    input  data_in_i, data_k_in_i, data_valid_i, pipe_width_i,
    output data_out_o, data_k_out_o, data_valid_o, lock_o, state_o
  );
endinterface

// File: rtl/gen1_descramble_byte_scramble.sv
// One symbol step of the descrambler: applies the COM/SKP/TS rules to one
// byte and hands the updated tracking state to the next byte lane.
//  active_i : lane carries a valid symbol; inactive lanes pass state through, output 0
//  sym_i/k_i: symbol and its K flag
//  dis_i    : pass D symbols unchanged (tracking still runs)
//  trk_i/o  : LFSR / state / os_cnt / lock before and after this symbol
//  sym_o    : descrambled (or passed-through) symbol
module gen1_descramble_byte_scramble
  import gen1_descramble_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT,
  parameter int          OS_LEN    = OS_LEN_DEFAULT
) (
  input  logic       active_i,
  input  logic [7:0] sym_i,
  input  logic       k_i,
  input  logic       dis_i,
  input  track_t     trk_i,
  output track_t     trk_o,
  output logic [7:0] sym_o
);

  localparam logic [3:0] CNT_LOAD = 4'(OS_LEN - 2);

  logic       is_com, is_skp, is_pad;
  logic [7:0] key;

  assign is_com = k_i && (sym_i == COM);
  assign is_skp = k_i && (sym_i == SKP);
  assign is_pad = k_i && (sym_i == PAD_);
  // Bit j of the key is the LFSR bit that will reach the MSB after j shifts.
  assign key = {trk_i.lfsr[8],  trk_i.lfsr[9],  trk_i.lfsr[10], trk_i.lfsr[11],
                trk_i.lfsr[12], trk_i.lfsr[13], trk_i.lfsr[14], trk_i.lfsr[15]};

  always_comb begin
    trk_o = trk_i;
    sym_o = 8'h00;
    if (active_i) begin
      sym_o = sym_i;
      if (is_com) begin
        trk_o.lfsr = LFSR_SEED;
        trk_o.st   = ST_OS_ID;
        trk_o.lock = 1'b1;
      end else begin
        // SKP symbols are inserted/removed by retimers, so they never advance.
        if (!is_skp) trk_o.lfsr = lfsr_adv8(trk_i.lfsr);
        case (trk_i.st)
          ST_OS_ID: begin
            // D or PAD right after COM means a TS1/TS2 body follows.
            if (k_i && !is_pad) begin
              trk_o.st = ST_SCRAMBLED;
            end else begin
              trk_o.st     = ST_TS_BYPASS;
              trk_o.os_cnt = CNT_LOAD;
            end
          end
          ST_TS_BYPASS: begin
            trk_o.os_cnt = (trk_i.os_cnt == 4'd0) ? 4'd0 : trk_i.os_cnt - 4'd1;
            if (trk_o.os_cnt == 4'd0) trk_o.st = ST_SCRAMBLED;
          end
          default: begin
            if (!k_i && !dis_i) sym_o = sym_i ^ key;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/gen1_descramble.sv
// Gen1/Gen2 (8b/10b) receive descrambler between PIPE RX and the RX parser.
// Two-cycle fixed latency: input register stage, then a registered stage
// that descrambles bytes 0..3 through a chain of symbol steps.
//  clk_i, rst_i (async, active high)
//  bus (slave modport of gen1_descramble_if): symbols/K/valid/pipe width in,
//      descrambled symbols/K/valid, lock_o and state_o out.
//  Optional: `GEN1_DESCRAMBLE_DIS_EN adds descramble_disable_i; while high,
//  D symbols pass unchanged and LFSR/ordered-set tracking keeps running.
module gen1_descramble
  import gen1_descramble_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT,
  parameter int          OS_LEN    = OS_LEN_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef GEN1_DESCRAMBLE_DIS_EN
  input  logic descramble_disable_i,
`endif
  gen1_descramble_if.slave bus
);

  typedef struct packed {
    logic [31:0] in_data;
    logic [3:0]  in_k;
    logic        in_valid;
    logic [2:0]  in_nbytes;
    logic [31:0] out_data;
    logic [3:0]  out_k;
    logic        out_valid;
    track_t      trk;
  } regs_t;

  regs_t      q, d;
  logic       dis;
  logic [3:0] act;
  track_t     t1, t2, t3, t4;
  logic [7:0] s0, s1, s2, s3;
  logic       unused_width_lsbs;

`ifdef GEN1_DESCRAMBLE_DIS_EN
  assign dis = descramble_disable_i;
`else
  assign dis = 1'b0;
`endif

  assign unused_width_lsbs = &{1'b0, bus.pipe_width_i[2:0]};

  // Lanes at or above the configured width carry no symbols.
  assign act[0] = q.in_valid && (q.in_nbytes > 3'd0);
  assign act[1] = q.in_valid && (q.in_nbytes > 3'd1);
  assign act[2] = q.in_valid && (q.in_nbytes > 3'd2);
  assign act[3] = q.in_valid && (q.in_nbytes > 3'd3);

  gen1_descramble_byte_scramble #(.LFSR_SEED(LFSR_SEED), .OS_LEN(OS_LEN)) u_b0 (
    .active_i(act[0]), .sym_i(q.in_data[7:0]), .k_i(q.in_k[0]), .dis_i(dis),
    .trk_i(q.trk), .trk_o(t1), .sym_o(s0));
  gen1_descramble_byte_scramble #(.LFSR_SEED(LFSR_SEED), .OS_LEN(OS_LEN)) u_b1 (
    .active_i(act[1]), .sym_i(q.in_data[15:8]), .k_i(q.in_k[1]), .dis_i(dis),
    .trk_i(t1), .trk_o(t2), .sym_o(s1));
  gen1_descramble_byte_scramble #(.LFSR_SEED(LFSR_SEED), .OS_LEN(OS_LEN)) u_b2 (
    .active_i(act[2]), .sym_i(q.in_data[23:16]), .k_i(q.in_k[2]), .dis_i(dis),
    .trk_i(t2), .trk_o(t3), .sym_o(s2));
  gen1_descramble_byte_scramble #(.LFSR_SEED(LFSR_SEED), .OS_LEN(OS_LEN)) u_b3 (
    .active_i(act[3]), .sym_i(q.in_data[31:24]), .k_i(q.in_k[3]), .dis_i(dis),
    .trk_i(t3), .trk_o(t4), .sym_o(s3));

  always_comb begin
    d           = q;
    d.in_data   = bus.data_in_i;
    d.in_k      = bus.data_k_in_i;
    d.in_valid  = bus.data_valid_i;
    d.in_nbytes = bus.pipe_width_i[5:3];
    d.out_data  = {s3, s2, s1, s0};
    d.out_k     = q.in_k & act;
    d.out_valid = q.in_valid;
    // With no active lane the chain passes the state through unchanged.
    d.trk       = t4;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q          <= '0;
      q.trk.lfsr <= LFSR_SEED;
    end else begin
      q <= d;
    end
  end

  assign bus.data_out_o   = q.out_data;
  assign bus.data_k_out_o = q.out_k;
  assign bus.data_valid_o = q.out_valid;
  assign bus.lock_o       = q.trk.lock;
  assign bus.state_o      = q.trk.st;

endmodule

// File: tb/tb_gen1_descramble.sv
module tb_gen1_descramble;
  localparam int W = 37;  // {lock, k[3:0], data[31:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dis = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int cur_nb = 4;

  logic [W-1:0] exp_q[$];
  int           due_q[$];
  logic [8:0]   sq[$];     // pending symbols {k, sym}

  logic [15:0] m_lfsr = 16'hFFFF;
  int          m_st   = 0;   // 0 unlocked, 1 os_id, 2 scrambled, 3 ts bypass
  int          m_cnt  = 0;
  logic        m_lock = 1'b0;

  gen1_descramble_if bus ();

  gen1_descramble dut (
    .clk_i (clk),
    .rst_i (rst),
`ifdef GEN1_DESCRAMBLE_DIS_EN
    .descramble_disable_i (dis),
`endif
    .bus (bus)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (bit-serial scrambler) ----------------
  function automatic logic [15:0] step(input logic [15:0] l);
    return l[15] ? ({l[14:0], 1'b0} ^ 16'h0039) : {l[14:0], 1'b0};
  endfunction

  function automatic logic [7:0] key_of(input logic [15:0] l);
    logic [15:0] s;
    logic [7:0]  k;
    s = l;
    for (int j = 0; j < 8; j++) begin
      k[j] = s[15];
      s = step(s);
    end
    return k;
  endfunction

  function automatic logic [15:0] adv8(input logic [15:0] l);
    logic [15:0] s;
    s = l;
    for (int j = 0; j < 8; j++) s = step(s);
    return s;
  endfunction

  task automatic model_beat(input logic [31:0] d, input logic [3:0] k,
                            output logic [31:0] od, output logic [3:0] ok);
    logic [7:0] sym, o;
    logic       kk;
    od = '0;
    ok = '0;
    for (int b = 0; b < cur_nb; b++) begin
      sym = d[8*b+:8];
      kk  = k[b];
      o   = sym;
      if (kk && sym == 8'hBC) begin
        m_lfsr = 16'hFFFF;
        m_st   = 1;
        m_lock = 1'b1;
      end else begin
        if (!kk && (m_st == 0 || m_st == 2) && !dis) o = sym ^ key_of(m_lfsr);
        if (m_st == 1) begin
          if (kk && sym != 8'hF7) m_st = 2;
          else begin
            m_st  = 3;
            m_cnt = 14;
          end
        end else if (m_st == 3) begin
          if (m_cnt > 0) m_cnt--;
          if (m_cnt == 0) m_st = 2;
        end
        if (!(kk && sym == 8'h1C)) m_lfsr = adv8(m_lfsr);
      end
      od[8*b+:8] = o;
      ok[b]      = kk;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] d, input logic [3:0] k,
                       input logic use_const, input logic [31:0] cd);
    logic [31:0] od;
    logic [3:0]  ok;
    @(negedge clk);
    model_beat(d, k, od, ok);
    bus.data_in_i    = d;
    bus.data_k_in_i  = k;
    bus.data_valid_i = 1'b1;
    exp_q.push_back({m_lock, ok, use_const ? cd : od});
    due_q.push_back(cyc + 2);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.data_valid_i = 1'b0;
      bus.data_in_i    = $urandom;
      bus.data_k_in_i  = 4'($urandom);
    end
  endtask

  task automatic add(input logic k, input logic [7:0] s);
    sq.push_back({k, s});
  endtask

  task automatic add_rand(input int n);
    repeat (n) add(1'b0, 8'($urandom));
  endtask

  task automatic add_d00(input int n);
    repeat (n) add(1'b0, 8'h00);
  endtask

  // Packs queued symbols into beats of the current width; unused lanes get junk.
  task automatic send_stream(input int max_gap, input logic tail_idle);
    logic [31:0] d;
    logic [3:0]  k;
    logic [8:0]  e;
    while (sq.size() % cur_nb != 0) sq.push_back(9'h000);
    while (sq.size() > 0) begin
      d = $urandom;
      k = 4'($urandom);
      for (int b = 0; b < cur_nb; b++) begin
        e = sq.pop_front();
        d[8*b+:8] = e[7:0];
        k[b]      = e[8];
      end
      drive(d, k, 1'b0, 32'h0);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
    if (tail_idle) idle(1);
  endtask

  task automatic set_width(input int w);
    idle(1);
    bus.pipe_width_i = 6'(w);
    cur_nb = w / 8;
    idle(2);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    int           due;
    if (!rst) begin
      if (bus.data_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("out_without_expect", bus.data_valid_o, 1'b0);
        end else begin
          e   = exp_q.pop_front();
          due = due_q.pop_front();
          chk("data", bus.data_out_o, e[31:0]);
          chk("k", bus.data_k_out_o, e[35:32]);
          chk("lock", bus.lock_o, e[36]);
          chk("latency", cyc, due);
        end
      end else begin
        chk("idle_data", bus.data_out_o, 32'h0);
        chk("idle_k", bus.data_k_out_o, 4'h0);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    bus.data_in_i    = '0;
    bus.data_k_in_i  = '0;
    bus.data_valid_i = 1'b0;
    bus.pipe_width_i = 6'd32;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.data_valid_o, 1'b0);
    chk("rst_data", bus.data_out_o, 32'h0);
    chk("rst_k", bus.data_k_out_o, 4'h0);
    chk("rst_lock", bus.lock_o, 1'b0);
    chk("rst_state", bus.state_o, 2'd0);
    rst = 1'b0;

    // Golden sequence from the seed: COM, SKP, then D00 symbols.
    drive(32'h0000_1CBC, 4'b0011, 1'b1, 32'h17FF_1CBC);
    drive(32'h0000_0000, 4'b0000, 1'b1, 32'hE7B2_14C0);
    drive(32'h0000_0000, 4'b0000, 1'b0, 32'h0);
    idle(1);

    for (int wi = 0; wi < 3; wi++) begin
      w = (wi == 0) ? 32 : (wi == 1) ? 16 : 8;
      set_width(w);
      // SKP ordered set: no LFSR advance on SKP.
      add(1'b1, 8'hBC); add(1'b1, 8'h1C); add(1'b1, 8'h1C); add(1'b1, 8'h1C);
      add_d00(4);
      send_stream(0, 1'b1);
      // TS1: 15 bypassed symbols, then scrambled D00 with key index 15.
      add(1'b1, 8'hBC); add(1'b0, 8'h01); add(1'b0, 8'h02); add_rand(13);
      add_d00(4);
      send_stream(0, 1'b1);
      // TS boundary mid-beat: scrambled D, COM at byte 2, TS body, scrambled tail.
      add_rand(2); add(1'b1, 8'hBC); add_rand(15); add_d00(6);
      send_stream(0, 1'b1);
      // PAD after COM also starts a bypassed ordered set; FTS does not.
      add(1'b1, 8'hBC); add(1'b1, 8'hF7); add_rand(14); add_d00(4);
      add(1'b1, 8'hBC); add(1'b1, 8'h3C); add_d00(2);
      send_stream(0, 1'b1);
    end

    // COM inside a TS body at width 16: restart, then SKP and D00 -> FF.
    set_width(16);
    add(1'b1, 8'hBC); add_rand(3); add(1'b1, 8'hBC); add(1'b1, 8'h1C); add_d00(4);
    send_stream(0, 1'b1);
    chk("state_after_restart", bus.state_o, 2'd2);

    // Valid gaps across a scrambled stream.
    set_width(32);
    add_rand(24);
    send_stream(2, 1'b1);

`ifdef GEN1_DESCRAMBLE_DIS_EN
    dis = 1'b1;
    add(1'b1, 8'hBC); add(1'b1, 8'h1C); add_d00(6);
    send_stream(0, 1'b1);
    dis = 1'b0;
    add_d00(4);
    send_stream(0, 1'b1);
`endif

    // Asynchronous reset while the pipeline is full.
    add(1'b1, 8'hBC); add(1'b1, 8'h3C); add_rand(10);
    send_stream(0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", bus.data_valid_o, 1'b0);
    chk("arst_data", bus.data_out_o, 32'h0);
    chk("arst_k", bus.data_k_out_o, 4'h0);
    chk("arst_lock", bus.lock_o, 1'b0);
    chk("arst_state", bus.state_o, 2'd0);
    exp_q.delete();
    due_q.delete();
    m_lfsr = 16'hFFFF;
    m_st   = 0;
    m_cnt  = 0;
    m_lock = 1'b0;
    bus.data_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    add_d00(4);
    send_stream(0, 1'b1);

    idle(4);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
